controlador_memoria: RTL and testbench

CONTROLADOR_MEMORIA -- requirements
Module: controlador_memoria

---
 rtl/controlador_memoria.sv | 140 ++++++++++++++
 tb/tb_controlador_memoria.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/controlador_memoria.sv
// Core-side data memory controller: turns LerMem/EscMem into a req/ack memory handshake and stalls the core.
// Optional 4-entry posted write buffer compiled in when CONTROLADOR_MEMORIA_WRITE_BUFFER_EN is defined.
module controlador_memoria (
    input  logic       Clock,
    input  logic       reset,
    input  logic       LerMem,
    input  logic       EscMem,
    input  logic [7:0] Endereco,
    input  logic [7:0] DadoEscrita,
    output logic [7:0] LeDado,
    output logic       Parada,
    output logic       mem_req,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ack
);
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;

    typedef enum logic [1:0] {OCIOSO, LEITURA, ESCRITA, FIM} estado_t;

    estado_t       estado;
    estado_t       prox_estado;
    logic [AW-1:0] end_sel;
    logic [DW-1:0] dado_sel;

`ifdef CONTROLADOR_MEMORIA_WRITE_BUFFER_EN
    localparam int unsigned PROF = 4;
    localparam int unsigned PW   = 2;
    localparam int unsigned CW   = PW + 1;
    // Buffered writes are not retired through FIM: the core already moved on at push time.
    localparam estado_t POS_ESCRITA = OCIOSO;

    logic [AW-1:0] fifo_end  [PROF];
    logic [DW-1:0] fifo_dado [PROF];
    logic [PW-1:0] ptr_esc;
    logic [PW-1:0] ptr_lei;
    logic [CW-1:0] ocupacao;
    logic          cheio;
    logic          vazio;
    logic          push;
    logic          pop;

    assign cheio = (ocupacao == CW'(PROF));
    assign vazio = (ocupacao == '0);
    assign pop   = (estado == ESCRITA) && mem_ack;
    // A full buffer still accepts a store in the cycle its head is acknowledged.
    assign push  = (estado != FIM) && EscMem && !LerMem && (!cheio || pop);

    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            ptr_esc  <= '0;
            ptr_lei  <= '0;
            ocupacao <= '0;
        end else begin
            if (push) ptr_esc <= ptr_esc + PW'(1);
            if (pop)  ptr_lei <= ptr_lei + PW'(1);
            ocupacao <= ocupacao + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge Clock) begin
        if (push) begin
            fifo_end[ptr_esc]  <= Endereco;
            fifo_dado[ptr_esc] <= DadoEscrita;
        end
    end
`else
    localparam estado_t POS_ESCRITA = FIM;
`endif

    // State register
    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) estado <= OCIOSO;
        else        estado <= prox_estado;
    end

    // Next-state logic
    always_comb begin
        prox_estado = estado;
        case (estado)
            OCIOSO: begin
`ifdef CONTROLADOR_MEMORIA_WRITE_BUFFER_EN
                // Pending writes drain before any load so program order holds.
                if (!vazio)      prox_estado = ESCRITA;
                else if (LerMem) prox_estado = LEITURA;
`else
                if (LerMem)      prox_estado = LEITURA;
                else if (EscMem) prox_estado = ESCRITA;
`endif
            end
            LEITURA: if (mem_ack) prox_estado = FIM;
            ESCRITA: if (mem_ack) prox_estado = POS_ESCRITA;
            FIM:     prox_estado = OCIOSO;
            default: prox_estado = OCIOSO;
        endcase
    end

    // Output logic: stall and source of the next memory transaction
    always_comb begin
        Parada   = 1'b0;
        end_sel  = Endereco;
        dado_sel = DadoEscrita;
`ifdef CONTROLADOR_MEMORIA_WRITE_BUFFER_EN
        if ((estado == OCIOSO) && !vazio) begin
            end_sel  = fifo_end[ptr_lei];
            dado_sel = fifo_dado[ptr_lei];
        end
        if (estado == LEITURA)  Parada = 1'b1;
        else if (estado != FIM) Parada = LerMem || (EscMem && !push);
`else
        case (estado)
            OCIOSO:  Parada = LerMem || EscMem;
            LEITURA: Parada = 1'b1;
            ESCRITA: Parada = 1'b1;
            default: Parada = 1'b0;
        endcase
`endif
        if (!reset) Parada = 1'b0;
    end

    // Registered memory interface and load data
    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            LeDado    <= '0;
        end else begin
            mem_req <= (prox_estado == LEITURA) || (prox_estado == ESCRITA);
            mem_we  <= (prox_estado == ESCRITA);
            if ((estado == OCIOSO) && (prox_estado != OCIOSO)) mem_addr  <= end_sel;
            if ((estado == OCIOSO) && (prox_estado == ESCRITA)) mem_wdata <= dado_sel;
            if ((estado == LEITURA) && mem_ack) LeDado <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_controlador_memoria.sv
// Directed, table-driven bench for controlador_memoria; extra buffer sequences when
// CONTROLADOR_MEMORIA_WRITE_BUFFER_EN is defined.
module tb_controlador_memoria;
    logic       Clock = 1'b0;
    logic       reset;
    logic       LerMem;
    logic       EscMem;
    logic [7:0] Endereco;
    logic [7:0] DadoEscrita;
    logic [7:0] LeDado;
    logic       Parada;
    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_ack;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        string      nome;
        logic       ler;
        logic       esc;
        logic [7:0] ende;
        logic [7:0] dado;
        logic [7:0] rdata;
        logic       ack;
        logic       exp_parada;
        logic       exp_req;
        logic       exp_we;
        logic [7:0] exp_addr;
        logic [7:0] exp_wdata;
        logic [7:0] exp_ledado;
    } vetor_t;

    vetor_t comum[$];
    vetor_t escrita[$];

`ifdef CONTROLADOR_MEMORIA_WRITE_BUFFER_EN
    logic [7:0] mem_modelo [256];
    logic [7:0] wa [5];
    logic [7:0] wd [5];
    int         got;
    int         escritas;
    logic       aceito;
    logic       fim;
`endif

    controlador_memoria dut (
        .Clock       (Clock),
        .reset       (reset),
        .LerMem      (LerMem),
        .EscMem      (EscMem),
        .Endereco    (Endereco),
        .DadoEscrita (DadoEscrita),
        .LeDado      (LeDado),
        .Parada      (Parada),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack)
    );

    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    task automatic chk1(input string nome, input logic atual, input logic esperado);
        n_chk++;
        if (atual !== esperado) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", nome, atual, esperado);
        end
    endtask

    task automatic chk8(input string nome, input logic [7:0] atual, input logic [7:0] esperado);
        n_chk++;
        if (atual !== esperado) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nome, atual, esperado);
        end
    endtask

    function automatic vetor_t mk(input string nome, input logic ler, input logic esc,
                                  input logic [7:0] ende, input logic [7:0] dado,
                                  input logic [7:0] rdata, input logic ack,
                                  input logic p, input logic r, input logic w,
                                  input logic [7:0] a, input logic [7:0] wdt, input logic [7:0] ld);
        vetor_t v;
        v.nome = nome; v.ler = ler; v.esc = esc; v.ende = ende; v.dado = dado;
        v.rdata = rdata; v.ack = ack; v.exp_parada = p; v.exp_req = r; v.exp_we = w;
        v.exp_addr = a; v.exp_wdata = wdt; v.exp_ledado = ld;
        return v;
    endfunction

    // One clock per vector: drive after the falling edge, sample 1 ns later.
    task automatic aplica(input vetor_t v);
        @(negedge Clock);
        LerMem = v.ler; EscMem = v.esc; Endereco = v.ende; DadoEscrita = v.dado;
        mem_rdata = v.rdata; mem_ack = v.ack;
        #1;
        chk1({v.nome, " Parada"},    Parada,    v.exp_parada);
        chk1({v.nome, " mem_req"},   mem_req,   v.exp_req);
        chk1({v.nome, " mem_we"},    mem_we,    v.exp_we);
        chk8({v.nome, " mem_addr"},  mem_addr,  v.exp_addr);
        chk8({v.nome, " mem_wdata"}, mem_wdata, v.exp_wdata);
        chk8({v.nome, " LeDado"},    LeDado,    v.exp_ledado);
    endtask

    initial begin
        // Load with 2 wait states, stray ack while idle, then simultaneous LerMem/EscMem.
        comum.push_back(mk("L0", 1, 0, 8'h12, 8'h00, 8'h00, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00));
        comum.push_back(mk("L1", 1, 0, 8'h12, 8'h00, 8'h00, 0, 1, 1, 0, 8'h12, 8'h00, 8'h00));
        comum.push_back(mk("L2", 1, 0, 8'h12, 8'h00, 8'h00, 0, 1, 1, 0, 8'h12, 8'h00, 8'h00));
        comum.push_back(mk("L3", 1, 0, 8'h12, 8'h00, 8'hA5, 1, 1, 1, 0, 8'h12, 8'h00, 8'h00));
        comum.push_back(mk("L4", 1, 0, 8'h12, 8'h00, 8'h00, 0, 0, 0, 0, 8'h12, 8'h00, 8'hA5));
        comum.push_back(mk("L5", 0, 0, 8'h12, 8'h00, 8'h00, 0, 0, 0, 0, 8'h12, 8'h00, 8'hA5));
        comum.push_back(mk("I0", 0, 0, 8'h12, 8'h00, 8'hFF, 1, 0, 0, 0, 8'h12, 8'h00, 8'hA5));
        comum.push_back(mk("I1", 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 8'h12, 8'h00, 8'hA5));
        comum.push_back(mk("T0", 1, 1, 8'h30, 8'h77, 8'h00, 0, 1, 0, 0, 8'h12, 8'h00, 8'hA5));
        comum.push_back(mk("T1", 1, 1, 8'h30, 8'h77, 8'h5A, 1, 1, 1, 0, 8'h30, 8'h00, 8'hA5));
        comum.push_back(mk("T2", 1, 1, 8'h30, 8'h77, 8'h00, 0, 0, 0, 0, 8'h30, 8'h00, 8'h5A));
        comum.push_back(mk("T3", 0, 0, 8'h30, 8'h77, 8'h00, 0, 0, 0, 0, 8'h30, 8'h00, 8'h5A));
        // Unbuffered store, one wait state.
        escrita.push_back(mk("S0", 0, 1, 8'h20, 8'h3C, 8'h00, 0, 1, 0, 0, 8'h30, 8'h00, 8'h5A));
        escrita.push_back(mk("S1", 0, 1, 8'h20, 8'h3C, 8'h00, 0, 1, 1, 1, 8'h20, 8'h3C, 8'h5A));
        escrita.push_back(mk("S2", 0, 1, 8'h20, 8'h3C, 8'h00, 1, 1, 1, 1, 8'h20, 8'h3C, 8'h5A));
        escrita.push_back(mk("S3", 0, 1, 8'h20, 8'h3C, 8'h00, 0, 0, 0, 0, 8'h20, 8'h3C, 8'h5A));
        escrita.push_back(mk("S4", 0, 0, 8'h20, 8'h3C, 8'h00, 0, 0, 0, 0, 8'h20, 8'h3C, 8'h5A));

        reset = 1'b0; LerMem = 0; EscMem = 0; Endereco = '0; DadoEscrita = '0;
        mem_rdata = '0; mem_ack = 0;
        #12;
        chk1("rst Parada", Parada, 1'b0);
        chk1("rst mem_req", mem_req, 1'b0);
        chk1("rst mem_we", mem_we, 1'b0);
        chk8("rst mem_addr", mem_addr, 8'h00);
        chk8("rst mem_wdata", mem_wdata, 8'h00);
        chk8("rst LeDado", LeDado, 8'h00);
        @(negedge Clock);
        reset = 1'b1;

        foreach (comum[i]) aplica(comum[i]);
`ifndef CONTROLADOR_MEMORIA_WRITE_BUFFER_EN
        foreach (escrita[i]) aplica(escrita[i]);
`endif

        // Reset asserted mid-load, then a late ack must be ignored.
        @(negedge Clock);
        LerMem = 1; EscMem = 0; Endereco = 8'h44; mem_ack = 0;
        @(negedge Clock);
        #1;
        chk1("rstmid req before", mem_req, 1'b1);
        reset = 1'b0;
        #1;
        chk1("rstmid mem_req", mem_req, 1'b0);
        chk1("rstmid Parada", Parada, 1'b0);
        chk8("rstmid LeDado", LeDado, 8'h00);
        chk8("rstmid mem_addr", mem_addr, 8'h00);
        LerMem = 0; mem_ack = 1; mem_rdata = 8'hEE;
        @(negedge Clock);
        reset = 1'b1;
        @(negedge Clock);
        #1;
        chk1("late ack mem_req", mem_req, 1'b0);
        chk8("late ack LeDado", LeDado, 8'h00);
        @(negedge Clock);
        #1;
        chk8("late ack LeDado 2", LeDado, 8'h00);
        mem_ack = 0;

`ifdef CONTROLADOR_MEMORIA_WRITE_BUFFER_EN
        // Five back-to-back stores against a silent memory: only the fifth stalls.
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            EscMem = 1; Endereco = 8'(i); DadoEscrita = 8'(8'h10 + i); mem_ack = 0;
            #1;
            chk1($sformatf("buf push %0d Parada", i), Parada, (i == 4));
        end
        got = 0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            @(negedge Clock);
            mem_ack = mem_req;
            #1;
            aceito = EscMem && !Parada;
            if (mem_req) begin
                wa[got] = mem_addr; wd[got] = mem_wdata; got++;
            end
            @(posedge Clock);
            #1;
            if (aceito) EscMem = 0;
        end
        chk8("drain count", 8'(got), 8'd5);
        for (int i = 0; i < 5; i++) begin
            chk8($sformatf("drain %0d addr", i), wa[i], 8'(i));
            chk8($sformatf("drain %0d data", i), wd[i], 8'(8'h10 + i));
        end
        @(negedge Clock);
        mem_ack = 0; EscMem = 0;

        // Two buffered stores then a load of one of them.
        for (int i = 0; i < 256; i++) mem_modelo[i] = 8'h00;
        @(negedge Clock);
        EscMem = 1; Endereco = 8'h00; DadoEscrita = 8'hAA;
        #1;
        chk1("ord st0 Parada", Parada, 1'b0);
        @(negedge Clock);
        Endereco = 8'h01; DadoEscrita = 8'hBB;
        #1;
        chk1("ord st1 Parada", Parada, 1'b0);
        escritas = 0; fim = 0;
        for (int c = 0; c < 40 && !fim; c++) begin
            @(negedge Clock);
            if (c == 0) begin
                EscMem = 0; LerMem = 1; Endereco = 8'h01;
            end
            mem_ack = mem_req;
            mem_rdata = mem_modelo[mem_addr];
            #1;
            if (mem_req && mem_we) begin
                mem_modelo[mem_addr] = mem_wdata;
                escritas++;
            end else if (mem_req) begin
                chk8("ord writes before load", 8'(escritas), 8'd2);
                chk8("ord load addr", mem_addr, 8'h01);
            end
            if (LerMem && !Parada) begin
                chk8("ord LeDado", LeDado, 8'hBB);
                fim = 1;
            end
        end
        chk1("ord load completed", fim, 1'b1);
        @(negedge Clock);
        LerMem = 0; mem_ack = 0;
`endif

        @(negedge Clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
